app_mult_seq_layer_acc: RTL and testbench

//  Iterative controller and accumulator for the signed 16x16 multiplier built around the signed16x2 partial-product layer.

---
 rtl/app_mult_seq_layer_acc.sv | 114 +++++++++++
 tb/tb_app_mult_seq_layer_acc.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/app_mult_seq_layer_acc.sv
// Iterative controller/accumulator for a signed A_W x B_W multiply built on an
// external signed 2-bit partial-product layer. One operand pair is latched,
// then one radix-4 digit of B is presented to the layer per cycle. Each
// returned partial product is sign-extended, shifted by 2k and accumulated.
module app_mult_seq_layer_acc #(
    parameter int A_W  = 16,
    parameter int B_W  = 16,
    parameter int PP_W = 18,
    parameter int P_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [A_W-1:0]  a_in,
    input  logic [B_W-1:0]  b_in,
    output logic [A_W-1:0]  layer_a,
    output logic            layer_b_low,
    output logic            layer_b_high,
    output logic            layer_cin,
    input  logic [PP_W-1:0] layer_sum,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [P_W-1:0]  product,
    output logic            busy
);

    localparam int DIGITS = B_W / 2;
    localparam int K_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [A_W-1:0]  r_a;
    logic [B_W-1:0]  r_b_sh;
    logic [P_W-1:0]  r_acc;
    logic [K_W-1:0]  r_k;

    logic [P_W-1:0]  w_pp_ext;
    logic [P_W-1:0]  w_pp_shifted;
    logic            w_last_digit;

    // Sign-extend the layer result to the product width, bit by bit: bits above
    // the partial-product MSB replicate its sign.
    genvar gi;
    generate
        for (gi = 0; gi < P_W; gi++) begin : g_sext
            if (gi < PP_W) begin : g_copy
                assign w_pp_ext[gi] = layer_sum[gi];
            end else begin : g_sign
                assign w_pp_ext[gi] = layer_sum[PP_W-1];
            end
        end
    endgenerate

    // Weight of digit k is 4^k; the shift follows sign extension so negative
    // partial products stay correct modulo 2^P_W.
    assign w_pp_shifted = w_pp_ext << {r_k, 1'b0};
    assign w_last_digit = (r_k == K_W'(DIGITS - 1));

    // Layer drive is decoded from registered state only, so in_* never reaches
    // the layer combinationally. Outside RUN the layer sees zeros.
    assign layer_a      = (r_state == S_RUN) ? r_a : '0;
    assign layer_b_low  = (r_state == S_RUN) ? r_b_sh[0] : 1'b0;
    assign layer_b_high = (r_state == S_RUN) ? r_b_sh[1] : 1'b0;
    assign layer_cin    = 1'b0;

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign product   = r_acc;

    // Control FSM plus datapath: latch operands, walk the digits, hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b_sh  <= '0;
            r_acc   <= '0;
            r_k     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a_in;
                        r_b_sh  <= b_in;
                        r_acc   <= '0;
                        r_k     <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc  <= r_acc + w_pp_shifted;
                    r_b_sh <= r_b_sh >> 2;
                    r_k    <= r_k + K_W'(1);
                    if (w_last_digit) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_app_mult_seq_layer_acc.sv
// Testbench for app_mult_seq_layer_acc: models the partial-product layer,
// drives directed and random operand pairs, and compares each emitted product
// against the plain signed product a*b modulo 2^32.
module tb_app_mult_seq_layer_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [15:0] layer_a;
    logic        layer_b_low;
    logic        layer_b_high;
    logic        layer_cin;
    logic [17:0] layer_sum;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int tb_k  = 0;

    always #5 clk = ~clk;

    app_mult_seq_layer_acc dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a_in         (a_in),
        .b_in         (b_in),
        .layer_a      (layer_a),
        .layer_b_low  (layer_b_low),
        .layer_b_high (layer_b_high),
        .layer_cin    (layer_cin),
        .layer_sum    (layer_sum),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    // Digit index seen by the layer model: restarts on accept, advances per RUN cycle.
    always @(posedge clk) begin
        if (rst)
            tb_k <= 0;
        else if (in_valid && in_ready)
            tb_k <= 0;
        else if (busy && !out_valid)
            tb_k <= tb_k + 1;
    end

    // Layer model: a * d_k, top digit signed, lower digits unsigned.
    always_comb begin
        int d;
        int p;
        d = 0;
        p = 0;
        if (tb_k == 7)
            d = -2 * int'(layer_b_high) + int'(layer_b_low);
        else
            d = 2 * int'(layer_b_high) + int'(layer_b_low);
        p = int'($signed(layer_a)) * d + int'(layer_cin);
        layer_sum = p[17:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("ready_while_busy", {31'b0, in_ready & busy}, 32'd0);
    endtask

    // One full transaction. inj: RUN cycle index at which to pulse a stray
    // in_valid (0 = none). hold: cycles out_ready stays low in DONE. rnd: random out_ready.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input int inj, input int hold, input bit rnd);
        logic [31:0] exp;
        int idx;
        int w;
        bit hs;
        exp = 32'(int'($signed(a)) * int'($signed(b)));
        w = 0;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        step();
        in_valid = 1'b0;
        a_in = $urandom;
        b_in = $urandom;
        chk("in_ready_drop", {31'b0, in_ready}, 32'd0);
        idx = 1;
        while (!out_valid && idx < 20) begin
            if (idx == inj) begin
                in_valid = 1'b1;
                a_in = 16'd7;
                b_in = 16'd7;
            end
            step();
            in_valid = 1'b0;
            idx++;
        end
        chk("latency", 32'(idx), 32'd9);
        if (!out_valid) return;
        chk("product", product, exp);
        hs = 1'b0;
        for (int i = 0; i < 200 && !hs; i++) begin
            out_ready = rnd ? 1'($urandom % 2) : (i >= hold);
            hs = out_ready;
            step();
            if (!hs) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_product", product, exp);
            end
        end
        out_ready = 1'b0;
        chk("valid_drop", {31'b0, out_valid}, 32'd0);
        chk("ready_after", {31'b0, in_ready}, 32'd1);
        $display("op a=%0d b=%0d product=0x%08h expected=0x%08h",
                 $signed(a), $signed(b), product, exp);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a_in = '0;
        b_in = '0;
        step();
        step();
        // Reset state
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_product", product, 32'd0);
        chk("rst_layer", {13'b0, layer_a, layer_b_high, layer_b_low, layer_cin}, 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_post_rst", {31'b0, in_ready}, 32'd1);

        // T1, T2
        run_op(16'd3, 16'd5, 0, 0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 0, 0, 1'b0);
        run_op(16'h8000, 16'h8000, 0, 0, 1'b0);
        run_op(16'h7FFF, 16'h8000, 0, 0, 1'b0);
        // T3: hold result 5 cycles
        run_op(16'd1234, 16'hFF85, 0, 5, 1'b0);
        // T4: stray in_valid during RUN
        run_op(16'hFFF3, 16'd21, 3, 0, 1'b0);

        // T5: reset at k=4
        in_valid = 1'b1;
        a_in = 16'd100;
        b_in = 16'd200;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("k_at_reset", 32'(tb_k), 32'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_acc", product, 32'd0);
        run_op(16'hFFFE, 16'd9, 0, 0, 1'b0);

        // T6: random back-to-back
        for (int n = 0; n < 1000; n++) begin
            run_op(16'($urandom), 16'($urandom), 0, 0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
